booth_seq_ctrl: RTL

- Multi-cycle sequencer for the radix-4 Booth multiply datapath (operand mux, shifters, ALU, product register), generalised to a WIDTH-bit multiplier.
- Accepts a start/busy/done request, latches the multiplier and recodes one Booth digit per cycle.
- Drives the datapath control set `load`, `muxsel`, `alu_op`, `shift_amount`, `tshift_amount` and `out_enable`, then signals completion.
- Sits between the top-level requester and the existing datapath.

---
 rtl/booth_pkg.sv | 12 +
 rtl/booth_recoder.sv | 41 ++++
 rtl/booth_seq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequencer: ALU opcodes, FSM states, recoded digits.
package booth_pkg;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0101;

  typedef enum logic [1:0] {IDLE, CLR, STEP, DONE} state_e;

  typedef enum logic [2:0] {D0, P1, P2, M2, M1} digit_e;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a signed digit and
// the datapath controls that realise it (zero select, add/sub, x1/x2 pre-shift).
module booth_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output digit_e     digit,
  output logic       muxsel,
  output logic [3:0] alu_op,
  output logic [2:0] shift_amount
);

  always_comb begin
    digit = D0;
    case (triplet)
      3'b001, 3'b010: digit = P1;
      3'b011:         digit = P2;
      3'b100:         digit = M2;
      3'b101, 3'b110: digit = M1;
      default:        digit = D0;
    endcase
  end

  // A zero digit still issues an ADD, but of the zero operand.
  always_comb begin
    muxsel       = 1'b0;
    alu_op       = ADD;
    shift_amount = 3'd0;
    case (digit)
      D0: muxsel = 1'b1;
      P2: shift_amount = 3'd1;
      M2: begin
        alu_op       = SUB;
        shift_amount = 3'd1;
      end
      M1: alu_op = SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Multi-cycle radix-4 Booth multiply sequencer (Moore outputs, one digit per STEP cycle).
// Optional early termination when the remaining multiplier bits are a pure sign run: BOOTH_EARLY_TERM_EN.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int NSTEP = WIDTH / 2,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic             acc_clr,
  output logic             load,
  output logic             muxsel,
  output logic [3:0]       alu_op,
  output logic [2:0]       shift_amount,
  output logic [SW-1:0]    tshift_amount,
  output logic             out_enable
);

  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] m_q, m_d;

  logic [WIDTH:0]   m_ext;
  logic [2:0]       triplet;
  logic             last_step;

  digit_e           rec_digit_unused;
  logic             rec_muxsel;
  logic [3:0]       rec_alu_op;
  logic [2:0]       rec_shift;

  // m[-1] is the implicit zero below the LSB, so triplet k starts at bit 2k of m_ext.
  assign m_ext   = {m_q, 1'b0};
  assign triplet = 3'(m_ext >> {step_q, 1'b0});

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0] upper;

  // Arithmetic shift leaves all-0s or all-1s exactly when m[WIDTH-1:2k+1] is a sign run.
  assign upper     = $signed(m_q) >>> {step_q, 1'b1};
  assign last_step = (step_q == LAST_STEP) || (upper == '0) || (upper == '1);
`else
  assign last_step = (step_q == LAST_STEP);
`endif

  booth_recoder u_recoder (
    .triplet      (triplet),
    .digit        (rec_digit_unused),
    .muxsel       (rec_muxsel),
    .alu_op       (rec_alu_op),
    .shift_amount (rec_shift)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplier;
          step_d  = '0;
          state_d = CLR;
        end
      end
      CLR:  state_d = STEP;
      STEP: begin
        if (last_step) state_d = DONE;
        else           step_d  = step_q + SW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    done          = 1'b0;
    acc_clr       = 1'b0;
    load          = 1'b0;
    muxsel        = 1'b0;
    alu_op        = NOP;
    shift_amount  = 3'd0;
    tshift_amount = '0;
    out_enable    = 1'b0;
    case (state_q)
      CLR: acc_clr = 1'b1;
      STEP: begin
        load          = 1'b1;
        muxsel        = rec_muxsel;
        alu_op        = rec_alu_op;
        shift_amount  = rec_shift;
        tshift_amount = step_q << 1;
      end
      DONE: begin
        done       = 1'b1;
        out_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
